// File: rtl/return_addr_stack.sv
// Return address stack for the fetch-stage branch predictor.
// Calls push their return address, returns pop it, and the current top entry
// is always presented as the predicted return target. Storage is circular:
// pushing onto a full stack overwrites the oldest entry so the newest return
// addresses survive deep call chains.
module return_addr_stack #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ras_pop_i,
  input  logic        ras_push_i,
  input  logic [63:0] ras_addr_i,
  output logic        ras_empty_o,
  output logic        ras_full_o,
  output logic [63:0] ras_addr_o
);

  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] TP_RESET = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    OP_IDLE     = 2'b00,
    OP_POP      = 2'b01,
    OP_PUSH     = 2'b10,
    OP_PUSH_POP = 2'b11
  } op_e;

  // Registered state
  logic [63:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] tp_q, tp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Write port for the entry array
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;

  logic is_empty;
  logic is_full;
  op_e  op;

  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == CNT_MAX);
  assign op       = op_e'({ras_push_i, ras_pop_i});

  // Next-state logic: decide pointer/count movement and which slot to write.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
    tp_d   = tp_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = tp_q;

    unique case (op)
      OP_PUSH: begin
        // Pointer wraps at PTR_W bits; on a full stack this lands on the oldest entry.
        tp_d   = tp_q + PTR_W'(1);
        wr_idx = tp_q + PTR_W'(1);
        wr_en  = 1'b1;
        cnt_d  = is_full ? cnt_q : cnt_q + CNT_W'(1);
      end
      OP_POP: begin
        // Popping an empty stack is a no-op: no underflow, no pointer wrap.
        // The popped slot keeps its contents; only the pointer moves.
        if (!is_empty) begin
          tp_d  = tp_q - PTR_W'(1);
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      OP_PUSH_POP: begin
        if (is_empty) begin
          // Nothing to return from, so behave as a plain push.
          tp_d   = tp_q + PTR_W'(1);
          wr_idx = tp_q + PTR_W'(1);
          wr_en  = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
        end else begin
          // Call-and-return: replace the top entry in place.
          wr_idx = tp_q;
          wr_en  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Pointer and count registers; reset parks tp so the first push hits slot 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: sequential state is updated with non-blocking assignments so all registers see pre-edge values.
      tp_q  <= TP_RESET;
      cnt_q <= '0;
    end else begin
      tp_q  <= tp_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry array; cleared on reset so stale addresses can never be predicted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the array is reset deliberately; it is small and a clean state is required after reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_idx] <= ras_addr_i;
    end
  end

  // Outputs are decoded straight from registered state.
  assign ras_empty_o = is_empty;
  assign ras_full_o  = is_full;
  assign ras_addr_o  = is_empty ? 64'd0 : mem_q[tp_q];

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed bench for return_addr_stack (DEPTH=4): a table of single-cycle
// vectors with hand-computed expected outputs, plus a few multi-cycle
// sequences for wrap-around and reset-override corner cases.
module tb_return_addr_stack;

  logic        clk_i;
  logic        rst_i;
  logic        ras_pop_i;
  logic        ras_push_i;
  logic [63:0] ras_addr_i;
  logic        ras_empty_o;
  logic        ras_full_o;
  logic [63:0] ras_addr_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        rst;
    logic        push;
    logic        pop;
    logic [63:0] addr;
    logic        exp_empty;
    logic        exp_full;
    logic [63:0] exp_addr;
  } vec_t;

  vec_t vecs[$];

  return_addr_stack #(.DEPTH(4)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .ras_pop_i  (ras_pop_i),
    .ras_push_i (ras_push_i),
    .ras_addr_i (ras_addr_i),
    .ras_empty_o(ras_empty_o),
    .ras_full_o (ras_full_o),
    .ras_addr_o (ras_addr_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive inputs away from the edge, then sample 1 time unit after the edge.
  task automatic step(input logic rst, input logic push, input logic pop, input logic [63:0] addr);
    @(negedge clk_i);
    rst_i      = rst;
    ras_push_i = push;
    ras_pop_i  = pop;
    ras_addr_i = addr;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_out(input string name, input logic e, input logic f, input logic [63:0] a);
    check({name, ".empty"}, {63'd0, ras_empty_o}, {63'd0, e});
    check({name, ".full"},  {63'd0, ras_full_o},  {63'd0, f});
    check({name, ".addr"},  ras_addr_o, a);
  endtask

  function automatic void add(input string name, input logic rst, input logic push, input logic pop,
                              input logic [63:0] addr, input logic e, input logic f, input logic [63:0] a);
    vec_t v;
    v.name = name; v.rst = rst; v.push = push; v.pop = pop; v.addr = addr;
    v.exp_empty = e; v.exp_full = f; v.exp_addr = a;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [63:0] vals [8];

    rst_i = 1'b1; ras_push_i = 1'b0; ras_pop_i = 1'b0; ras_addr_i = '0;

    //   name             rst push pop addr            empty full exp_addr
    add("reset",          1, 0, 0, 64'h0,            1, 0, 64'h0);
    add("idle",           0, 0, 0, 64'hDEAD_BEEF,    1, 0, 64'h0);
    add("fill1",          0, 1, 0, 64'h100,          0, 0, 64'h100);
    add("fill2",          0, 1, 0, 64'h200,          0, 0, 64'h200);
    add("fill3",          0, 1, 0, 64'h300,          0, 0, 64'h300);
    add("fill4",          0, 1, 0, 64'h400,          0, 1, 64'h400);
    add("overflow",       0, 1, 0, 64'h64,           0, 1, 64'h64);
    add("drain_pop",      0, 0, 1, 64'h0,            0, 0, 64'h400);
    add("drain_push",     0, 1, 0, 64'hC8,           0, 1, 64'hC8);
    add("drain_pop1",     0, 0, 1, 64'h0,            0, 0, 64'h400);
    add("drain_pop2",     0, 0, 1, 64'h0,            0, 0, 64'h300);
    add("drain_pop3",     0, 0, 1, 64'h0,            0, 0, 64'h200);
    add("drain_pop4",     0, 0, 1, 64'h0,            1, 0, 64'h0);
    add("underflow",      0, 0, 1, 64'h0,            1, 0, 64'h0);
    add("post_uflow",     0, 1, 0, 64'h100,          0, 0, 64'h100);
    add("post_uflow_pop", 0, 0, 1, 64'h0,            1, 0, 64'h0);
    add("lifo_push1",     0, 1, 0, 64'h100,          0, 0, 64'h100);
    add("lifo_push2",     0, 1, 0, 64'h200,          0, 0, 64'h200);
    add("lifo_pop1",      0, 0, 1, 64'h0,            0, 0, 64'h100);
    add("lifo_pop2",      0, 0, 1, 64'h0,            1, 0, 64'h0);
    add("lifo_pop3",      0, 0, 1, 64'h0,            1, 0, 64'h0);
    add("pp_push10",      0, 1, 0, 64'h10,           0, 0, 64'h10);
    add("pp_push20",      0, 1, 0, 64'h20,           0, 0, 64'h20);
    add("pp_both30",      0, 1, 1, 64'h30,           0, 0, 64'h30);
    add("pp_pop1",        0, 0, 1, 64'h0,            0, 0, 64'h10);
    add("pp_pop2",        0, 0, 1, 64'h0,            1, 0, 64'h0);
    add("pp_empty40",     0, 1, 1, 64'h40,           0, 0, 64'h40);
    add("pp_empty_pop",   0, 0, 1, 64'h0,            1, 0, 64'h0);
    add("addr_ignored",   0, 0, 0, 64'hFFFF_FFFF,    1, 0, 64'h0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].push, vecs[i].pop, vecs[i].addr);
      check_out(vecs[i].name, vecs[i].exp_empty, vecs[i].exp_full, vecs[i].exp_addr);
    end

    // Wrap the pointer twice around the ring; only the newest four survive.
    for (int i = 0; i < 8; i++) begin
      vals[i] = 64'h1000 * (i + 1) + 64'h7;
      step(1'b0, 1'b1, 1'b0, vals[i]);
      check_out($sformatf("wrap_push%0d", i), 1'b0, (i >= 3), vals[i]);
    end
    for (int i = 7; i >= 5; i--) begin
      step(1'b0, 1'b0, 1'b1, 64'h0);
      check_out($sformatf("wrap_pop%0d", i), 1'b0, 1'b0, vals[i-1]);
    end
    step(1'b0, 1'b0, 1'b1, 64'h0);
    check_out("wrap_pop_last", 1'b1, 1'b0, 64'h0);

    // Reset mid-sequence overrides a concurrent push and discards entries.
    step(1'b0, 1'b1, 1'b0, 64'hA1);
    step(1'b0, 1'b1, 1'b0, 64'hA2);
    check_out("pre_reset", 1'b0, 1'b0, 64'hA2);
    step(1'b1, 1'b1, 1'b1, 64'hA3);
    check_out("reset_override", 1'b1, 1'b0, 64'h0);
    step(1'b0, 1'b0, 1'b1, 64'h0);
    check_out("reset_then_pop", 1'b1, 1'b0, 64'h0);
    step(1'b0, 1'b1, 1'b0, 64'hB5);
    check_out("reset_then_push", 1'b0, 1'b0, 64'hB5);
    step(1'b0, 1'b0, 1'b1, 64'h0);
    check_out("reset_then_pop2", 1'b1, 1'b0, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/return_addr_stack.md
Name: return_addr_stack

Overview:
- Return address stack (RAS) for the branch predictor in the fetch stage.
- Calls push their return address. Returns pop it. The current top entry is always presented as the predicted return target.
- Circular storage: a push to a full stack overwrites the oldest entry, so the most recent return addresses are never lost.

Parameters:
- DEPTH, 4, number of 64-bit entries. Must be a power of two and at least 2.
- PTR_W, $clog2(DEPTH), pointer width. Derived; not overridden.

Ports:
- clk_i  input  1  clock; all state updates on its rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- ras_pop_i  input  1  pop request (return instruction), sampled at the rising edge.
- ras_push_i  input  1  push request (call instruction), sampled at the rising edge.
- ras_addr_i  input  64  return address to push; valid when ras_push_i=1.
- ras_empty_o  output  1  1 when the entry count is 0.
- ras_full_o  output  1  1 when the entry count equals DEPTH.
- ras_addr_o  output  64  current top-of-stack address; 0 when empty.

Behaviour:
- State:
  - Entry array mem[DEPTH] x 64.
  - Top pointer tp (PTR_W bits): index of the current top entry.
  - Count cnt (PTR_W+1 bits), range 0..DEPTH.
- Reset (rst_i=1 at a rising edge):
  - tp=DEPTH-1 (so the first push lands in slot 0), cnt=0, all mem entries=0.
  - Outputs after reset: ras_empty_o=1, ras_full_o=0, ras_addr_o=0.
  - Reset overrides push and pop in the same cycle. Reset mid-sequence discards all entries.
- Outputs are purely combinational from registered state; no output registers:
  - ras_empty_o = (cnt==0).
  - ras_full_o = (cnt==DEPTH).
  - ras_addr_o = (cnt==0) ? 0 : mem[tp].
- Latency: a push or pop sampled at edge N is visible on the outputs immediately after edge N. A pushed address appears on ras_addr_o one edge after the push.
- Push only (push=1, pop=0):
  - tp=tp+1 modulo DEPTH; mem[tp+1]=ras_addr_i; cnt=min(cnt+1, DEPTH).
  - When full, the write lands on the oldest entry, overwriting it. cnt stays DEPTH; ras_full_o stays 1.
- Pop only (push=0, pop=1):
  - If cnt>0: tp=tp-1 modulo DEPTH; cnt=cnt-1. The popped entry's contents are left in place.
  - If cnt==0: no state change. ras_empty_o stays 1; ras_addr_o stays 0. No underflow and no wrap of tp.
- Push and pop in the same cycle (call-and-return):
  - If cnt>0: mem[tp]=ras_addr_i. tp and cnt are unchanged (top is replaced).
  - If cnt==0: treated as a plain push.
- Neither asserted: hold all state.
- Pointer arithmetic wraps naturally at PTR_W bits. cnt never exceeds DEPTH and never goes below 0.
- ras_addr_i is ignored when ras_push_i=0. ras_addr_i is not stored or validated beyond 64-bit capture.

Test Plan:
- Reset, then idle:
  - Required: ras_empty_o=1, ras_full_o=0, ras_addr_o=0.
  - Assert rst_i for one edge after arbitrary pushes; the same values are required.
- Fill, then overflow:
  - Push 0x100, 0x200, 0x300, 0x400 → ras_addr_o follows each push; after the 4th push ras_full_o=1, ras_addr_o=0x400.
  - Push 0x64 → ras_full_o stays 1, ras_addr_o=0x64; the oldest entry 0x100 is overwritten.
- Drain after overflow:
  - Pop → ras_addr_o=0x400, full=0.
  - Push 0xC8 → ras_addr_o=0xC8, full=1.
  - Four pops → ras_addr_o sequence 0x400, 0x300, 0x200, then empty=1 with ras_addr_o=0. The value 0x100 must never reappear.
- Underflow:
  - Pop while empty → empty=1, ras_addr_o=0, no state change.
  - Push 0x100 → ras_addr_o=0x100 (not corrupted by the earlier underflow).
- LIFO order:
  - Push 0x100, push 0x200 → top=0x200.
  - Pop → top=0x100.
  - Pop → empty.
  - Pop → still empty.
- Simultaneous push+pop:
  - With stack [0x10, 0x20], assert both with ras_addr_i=0x30 → top=0x30, count unchanged (one pop then reaches 0x10).
  - On an empty stack, assert both with ras_addr_i=0x40 → top=0x40, empty=0.
